// File: rtl/onehot_scan_pkg.sv
// Purpose: shared encodings for the one-hot scan decoder.
//   MODE_DIRECT / MODE_SCAN : values of the mode input.
//   state_t                 : controller state (IDLE, DIRECT, SCAN).
package onehot_scan_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

endpackage

// File: rtl/onehot_dec.sv
// Purpose: combinational enabled binary-to-one-hot decoder, built as a tree
// of 2:4 enabled stages (plus a 1:2 top stage when SEL_W is odd). The high
// select bits produce enables that gate the stages decoding the low bits.
// Ports:
//   sel    [SEL_W-1:0]     binary index
//   enb                    0 forces all outputs low
//   onehot [2**SEL_W-1:0]  decoded output, bit sel set when enb=1
module onehot_dec #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic                  enb,
  output logic [2**SEL_W-1:0]   onehot
);

  localparam int ODD   = SEL_W % 2;
  localparam int NPAIR = SEL_W / 2;

  // Level l holds the enables after the top stage and l pair stages; each
  // enable line at level l-1 fans out into four lines at level l, so the
  // final level is already in binary index order.
  for (genvar l = 0; l <= NPAIR; l++) begin : g_lvl
    localparam int W = 1 << (ODD + 2 * l);
    logic [W-1:0] en;

    if (l == 0) begin : g_top
      if (ODD == 1) begin : g_odd
        assign en = {enb & sel[SEL_W-1], enb & ~sel[SEL_W-1]};
      end else begin : g_even
        assign en = enb;
      end
    end else begin : g_pair
      localparam int LSB = SEL_W - ODD - 2 * l;
      logic [1:0] s;
      assign s = sel[LSB +: 2];
      for (genvar k = 0; k < W / 4; k++) begin : g_stage
        for (genvar m = 0; m < 4; m++) begin : g_bit
          assign en[4 * k + m] = g_lvl[l-1].en[k] & (s == 2'(m));
        end
      end
    end
  end

  assign onehot = g_lvl[NPAIR].en;

endmodule

// File: rtl/onehot_scan_decoder.sv
// Purpose: registered one-hot decoder with a self-sequencing scan mode.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   enb                  0 -> outputs cleared, index and dwell count frozen
//   mode                 MODE_DIRECT / MODE_SCAN
//   sel_in [SEL_W-1:0]   direct index; load value in scan
//   load                 scan only: jump to sel_in and restart the dwell
//   dwell  [DWELL_W-1:0] scan hold time minus one, latched at each restart
//   out    [OUT_W-1:0]   registered one-hot of cur_sel, zero when invalid
//   cur_sel[SEL_W-1:0]   registered index shown on out
//   wrap                 one-cycle pulse on the OUT_W-1 -> 0 scan step
//   out_valid            out holds a decoded value
//
// state  | meaning
// IDLE   | disabled: out cleared, index and dwell count frozen
// DIRECT | out follows sel_in with one cycle of latency
// SCAN   | index advances after dwell_latched+1 cycles, wraps modulo OUT_W
module onehot_scan_decoder
  import onehot_scan_pkg::*;
#(
  parameter int  SEL_W   = 3,
  parameter int  DWELL_W = 4,
  localparam int OUT_W   = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enb,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   out,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               wrap,
  output logic               out_valid
);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic [DWELL_W-1:0] dwell_cnt, cnt_nxt;
  logic [DWELL_W-1:0] dwell_latched, lat_nxt;
  logic               wrap_nxt;
  logic               valid_nxt;
  logic [OUT_W-1:0]   dec_onehot;

  always_comb begin
    state_nxt = IDLE;
    sel_nxt   = cur_sel;
    cnt_nxt   = dwell_cnt;
    lat_nxt   = dwell_latched;
    wrap_nxt  = 1'b0;
    valid_nxt = 1'b0;

    if (enb) begin
      state_nxt = (mode == MODE_DIRECT) ? DIRECT : SCAN;
    end

    case (state_nxt)
      DIRECT: begin
        // Counter is held at its restart point, so dwell is re-sampled too.
        sel_nxt   = sel_in;
        cnt_nxt   = '0;
        lat_nxt   = dwell;
        valid_nxt = 1'b1;
      end
      SCAN: begin
        valid_nxt = 1'b1;
        if (load) begin
          sel_nxt = sel_in;
          cnt_nxt = '0;
          lat_nxt = dwell;
        end else if (state == DIRECT) begin
          // Entering scan: keep the current index and start a fresh dwell.
          cnt_nxt = '0;
          lat_nxt = dwell;
        end else if (dwell_cnt == dwell_latched) begin
          sel_nxt  = cur_sel + SEL_W'(1);
          cnt_nxt  = '0;
          lat_nxt  = dwell;
          wrap_nxt = (cur_sel == {SEL_W{1'b1}});
        end else begin
          cnt_nxt = dwell_cnt + DWELL_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Decode the next index so out lines up with cur_sel in the same cycle.
  onehot_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .sel    (sel_nxt),
    .enb    (valid_nxt),
    .onehot (dec_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cur_sel       <= '0;
      dwell_cnt     <= '0;
      dwell_latched <= '0;
      out           <= '0;
      wrap          <= 1'b0;
      out_valid     <= 1'b0;
    end else begin
      state         <= state_nxt;
      cur_sel       <= sel_nxt;
      dwell_cnt     <= cnt_nxt;
      dwell_latched <= lat_nxt;
      out           <= dec_onehot;
      wrap          <= wrap_nxt;
      out_valid     <= valid_nxt;
    end
  end

endmodule

// File: doc/onehot_scan_decoder.md
Name: onehot_scan_decoder

Overview:
- Parametrised, registered one-hot decoder. Generalises the fixed 3:8 enable-decoder to SEL_W select bits and 2^SEL_W outputs.
- Adds an auto-scan mode: an internal index walks every output in turn, holding each for a programmable dwell time.
- Used to drive channel or row selects for multiplexed peripherals, either CPU-directed or self-sequencing.

Parameters:
- SEL_W, 3, select width; output width OUT_W = 2**SEL_W (localparam, not overridable); legal range 1..6.
- DWELL_W, 4, width of the dwell-count input and the internal dwell counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- enb  input  1  global enable; 0 forces outputs to zero and freezes counters.
- mode  input  1  0 = DIRECT, 1 = SCAN.
- sel_in  input  SEL_W  direct select value; also the load value in SCAN.
- load  input  1  SCAN only: index <= sel_in, dwell counter cleared.
- dwell  input  DWELL_W  hold each index for dwell+1 cycles in SCAN; sampled whenever the dwell counter restarts.
- out  output  OUT_W  registered one-hot output; all zero when disabled.
- cur_sel  output  SEL_W  registered index currently decoded onto out.
- wrap  output  1  one-cycle pulse when the SCAN index steps from OUT_W-1 to 0.
- out_valid  output  1  high whenever out holds a decoded (non-zero) value.

Behaviour:
- Reset (async, rst_n=0): out=0, cur_sel=0, wrap=0, out_valid=0, dwell_cnt=0, state=IDLE. Reset takes effect immediately, mid-scan included. The first edge after release behaves as a normal cycle.
- States: IDLE, DIRECT, SCAN, evaluated every clk edge.
  - enb=0 -> IDLE.
  - enb=1 and mode=0 -> DIRECT.
  - enb=1 and mode=1 -> SCAN.
- IDLE:
  - out=0, out_valid=0, wrap=0.
  - cur_sel and dwell_cnt hold.
- DIRECT:
  - Each cycle: cur_sel <= sel_in, out <= onehot(sel_in), out_valid <= 1. Latency is 1 cycle from sel_in to out.
  - dwell_cnt <= 0; load is ignored; wrap=0.
- SCAN:
  - Dwell handling: out = onehot(cur_sel); dwell_cnt increments each cycle. When dwell_cnt == dwell_latched, the index steps (cur_sel <= cur_sel+1 mod OUT_W) and dwell_cnt <= 0. dwell_latched <= dwell is captured at that restart.
  - Wrap: on a step from OUT_W-1 to 0, wrap=1 for exactly that cycle; otherwise wrap=0.
  - dwell=0 means the index steps every cycle.
  - load=1: cur_sel <= sel_in, dwell_cnt <= 0, dwell_latched <= dwell, no wrap. load beats a step in the same cycle.
- Mode and enable transitions:
  - DIRECT->SCAN: scan continues from the current cur_sel, with dwell_cnt=0 and dwell_latched <= dwell.
  - SCAN->DIRECT: takes effect next edge; any pending step is discarded.
  - enb falling mid-dwell freezes cur_sel and dwell_cnt. enb rising in SCAN resumes from the frozen count.
- Arithmetic and output invariants:
  - Index increment is modulo 2**SEL_W with natural overflow.
  - dwell_cnt is DWELL_W wide, with no overflow beyond dwell_latched.
  - out is one-hot, or all-zero when out_valid=0, at all times.

Decomposition:
- Package onehot_scan_pkg:
  - mode encodings MODE_DIRECT=1'b0, MODE_SCAN=1'b1;
  - state enum {IDLE, DIRECT, SCAN}.
- Sub-module onehot_dec: combinational, parameter SEL_W, ports sel, enb, onehot.
  - Built by generate as a tree of 2:4 enabled stages: the high select bits enable the low-bit stages.
  - Odd SEL_W uses a 1:2 top stage.
  - Instantiated once, on the next-state index; its output is registered in the top module.

Test Plan:
- Reset/direct: rst_n=0 then 1, enb=1, mode=0, sel_in=5 -> next edge out=8'b0010_0000, cur_sel=5, out_valid=1. Assert rst_n=0 mid-cycle -> out=0 immediately.
- Scan with dwell: mode=1, dwell=2, start cur_sel=6.
  - out=0x40 for 3 cycles, then 0x80 for 3 cycles, then 0x01.
  - wrap=1 only on the 7->0 step cycle.
- Scan with dwell=0: the index steps every cycle. Sequence 0x01, 0x02, ..., 0x80, 0x01, with wrap pulsing once per 8 cycles.
- Load vs step collision: dwell=1 and load=1, sel_in=3 on the step cycle -> cur_sel=3, out=0x08, wrap=0, 2-cycle dwell restarts.
- Enable freeze: SCAN dwell=3, drop enb after 2 cycles at index 4 -> out=0, out_valid=0. Raise enb -> index 4 held for 2 more cycles, then steps to 5.
- Parameter sweep: SEL_W=1, 4 and 5 with DWELL_W=2.
  - Direct decode of every value gives exactly one hot bit at position sel_in.
  - Scan wraps at 2, 16 and 32 respectively.
